// File: rtl/dadd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dadd_pkg
//  Brief    : Shared types and the overflow-aware adder used by dadd_mch.
//  Revision : 1.0 - initial multi-channel release
// ============================================================================
package dadd_pkg;

   // Widest data/address/channel fields a stage record can carry.
   localparam int c_DW_MAX = 64;
   localparam int c_AW_MAX = 64;
   localparam int c_CW_MAX = 16;

   typedef enum logic {
      DADD_ADD = 1'b0,
      DADD_ACC = 1'b1
   } dadd_mode_e;

   // One pipeline stage; instances only use the low DW/AW/CW bits.
   typedef struct packed {
      logic                vld;
      logic [c_CW_MAX-1:0] ch;
      logic [c_AW_MAX-1:0] addr;
      logic [c_DW_MAX-1:0] data;
      logic                ovf;
   } dadd_stage_t;

   // Adds two dw-bit operands (zero-extended into c_DW_MAX bits).
   // Returns {ovf, result}; with sat set an overflow clamps to all-ones.
   function automatic logic [c_DW_MAX:0] sat_add(
      input logic [c_DW_MAX-1:0] a,
      input logic [c_DW_MAX-1:0] b,
      input logic                sat,
      input int                  dw
   );
      logic [c_DW_MAX:0]   w_sum;
      logic [c_DW_MAX:0]   w_mask;
      logic                w_carry;
      logic [c_DW_MAX-1:0] w_res;
      w_sum   = {1'b0, a} + {1'b0, b};
      w_mask  = ({{c_DW_MAX{1'b0}}, 1'b1} << dw) - 1'b1;
      // Operands fit in dw bits, so anything above the mask is the carry.
      w_carry = |(w_sum & ~w_mask);
      w_res   = w_sum[c_DW_MAX-1:0] & w_mask[c_DW_MAX-1:0];
      if (w_carry && sat) begin
         w_res = w_mask[c_DW_MAX-1:0];
      end
      return {w_carry, w_res};
   endfunction

endpackage
`default_nettype wire

// File: rtl/dadd_chan_regs.sv
`default_nettype none
// ============================================================================
//  Module   : dadd_chan_regs
//  Brief    : Per-channel addend / mode / accumulator register file with a
//             config write port, a read port and an accumulator write-back.
//  Revision : 1.0 - initial multi-channel release
// ============================================================================
module dadd_chan_regs
   import dadd_pkg::*;
#(
   parameter int DW  = 32,
   parameter int NCH = 4,
   parameter int CW  = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_cfg_we,
   input  logic [CW-1:0] i_cfg_ch,
   input  logic          i_cfg_mode,
   input  logic [DW-1:0] i_cfg_addend,
   input  logic [CW-1:0] i_rd_ch,
   output dadd_mode_e    o_rd_mode,
   output logic [DW-1:0] o_rd_addend,
   output logic [DW-1:0] o_rd_acc,
   input  logic          i_wb_en,
   input  logic [CW-1:0] i_wb_ch,
   input  logic [DW-1:0] i_wb_data
);

   localparam logic [CW:0] c_NCH = (CW+1)'(NCH);

   logic [DW-1:0] r_addend [NCH];
   dadd_mode_e    r_mode   [NCH];
   logic [DW-1:0] r_acc    [NCH];
   logic          w_rd_ok;

   // Config write beats accumulator write-back on the same channel, so a
   // same-cycle config always leaves the accumulator cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            r_addend[i] <= '0;
            r_mode[i]   <= DADD_ADD;
            r_acc[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (i_cfg_we && (i_cfg_ch == CW'(i))) begin
               r_addend[i] <= i_cfg_addend;
               r_mode[i]   <= dadd_mode_e'(i_cfg_mode);
               r_acc[i]    <= '0;
            end else if (i_wb_en && (i_wb_ch == CW'(i))) begin
               r_acc[i]    <= i_wb_data;
            end
         end
      end
   end

   // Out-of-range channels read as an ADD of zero.
   assign w_rd_ok     = ({1'b0, i_rd_ch} < c_NCH);
   assign o_rd_mode   = w_rd_ok ? r_mode[i_rd_ch]   : DADD_ADD;
   assign o_rd_addend = w_rd_ok ? r_addend[i_rd_ch] : '0;
   assign o_rd_acc    = w_rd_ok ? r_acc[i_rd_ch]    : '0;

endmodule
`default_nettype wire

// File: rtl/dadd_mch.sv
`default_nettype none
// ============================================================================
//  Module   : dadd_mch
//  Brief    : Multi-channel add/accumulate datapath with a fixed-latency,
//             stall-able pipeline; address and channel ride alongside.
//  Revision : 1.0 - initial multi-channel release
// ============================================================================
module dadd_mch
   import dadd_pkg::*;
#(
   parameter  int DW  = 32,
   parameter  int AW  = 32,
   parameter  int NCH = 4,
   parameter  int LAT = 2,
   parameter  int SAT = 0,
   localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cfg_we,
   input  logic [CW-1:0] cfg_ch,
   input  logic          cfg_mode,
   input  logic [DW-1:0] cfg_addend,
   input  logic          dadd_in_en,
   output logic          dadd_in_rdy,
   input  logic [CW-1:0] dadd_in_ch,
   input  logic [AW-1:0] dadd_in_addr,
   input  logic [DW-1:0] dadd_in,
   output logic          dadd_out_en,
   input  logic          dadd_out_rdy,
   output logic [CW-1:0] dadd_out_ch,
   output logic [AW-1:0] dadd_out_addr,
   output logic [DW-1:0] dadd_out,
   output logic          dadd_out_ovf
);

   localparam logic [CW:0] c_NCH = (CW+1)'(NCH);

   dadd_stage_t       r_pipe [LAT];
   dadd_stage_t       w_new;
   logic              w_stall;
   logic              w_accept;
   logic              w_in_range;
   dadd_mode_e        w_rd_mode;
   logic [DW-1:0]     w_rd_addend;
   logic [DW-1:0]     w_rd_acc;
   logic [DW-1:0]     w_opa;
   logic [c_DW_MAX:0] w_sum;
   logic [DW-1:0]     w_res;
   logic              w_ovf;
   logic              w_wb_en;
   logic              w_unused;

   // Only a valid, unaccepted result at the output can hold the pipe.
   assign w_stall     = r_pipe[LAT-1].vld & ~dadd_out_rdy;
   assign dadd_in_rdy = ~reset & ~w_stall;
   assign w_accept    = dadd_in_en & dadd_in_rdy;
   assign w_in_range  = ({1'b0, dadd_in_ch} < c_NCH);

   dadd_chan_regs #(
      .DW  (DW),
      .NCH (NCH),
      .CW  (CW)
   ) u_regs (
      .clk          (clk),
      .rst          (reset),
      .i_cfg_we     (cfg_we),
      .i_cfg_ch     (cfg_ch),
      .i_cfg_mode   (cfg_mode),
      .i_cfg_addend (cfg_addend),
      .i_rd_ch      (dadd_in_ch),
      .o_rd_mode    (w_rd_mode),
      .o_rd_addend  (w_rd_addend),
      .o_rd_acc     (w_rd_acc),
      .i_wb_en      (w_wb_en),
      .i_wb_ch      (dadd_in_ch),
      .i_wb_data    (w_res)
   );

   // Result is computed at accept time so back-to-back ACC beats chain.
   assign w_opa   = (w_rd_mode == DADD_ACC) ? w_rd_acc : w_rd_addend;
   assign w_sum   = sat_add(c_DW_MAX'(w_opa), c_DW_MAX'(dadd_in), (SAT != 0), DW);
   assign w_res   = w_sum[DW-1:0];
   assign w_ovf   = w_sum[c_DW_MAX];
   assign w_wb_en = w_accept & w_in_range & (w_rd_mode == DADD_ACC);

   // Build the stage-0 record; out-of-range beats carry a zero result.
   always_comb begin
      w_new      = '0;
      w_new.vld  = 1'b1;
      w_new.ch   = c_CW_MAX'(dadd_in_ch);
      w_new.addr = c_AW_MAX'(dadd_in_addr);
      if (w_in_range) begin
         w_new.data = c_DW_MAX'(w_res);
         w_new.ovf  = w_ovf;
      end
   end

   // Shift register of LAT stages sharing one stall enable; idle cycles
   // enter as bubbles.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LAT; i++) begin
            r_pipe[i] <= '0;
         end
      end else if (!w_stall) begin
         r_pipe[0] <= w_accept ? w_new : '0;
         for (int i = 1; i < LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign dadd_out_en   = r_pipe[LAT-1].vld;
   assign dadd_out_ch   = r_pipe[LAT-1].ch[CW-1:0];
   assign dadd_out_addr = r_pipe[LAT-1].addr[AW-1:0];
   assign dadd_out      = r_pipe[LAT-1].data[DW-1:0];
   assign dadd_out_ovf  = r_pipe[LAT-1].ovf;

   // Upper bits of the wide stage record and adder are intentionally idle.
   assign w_unused = ^{r_pipe[LAT-1], w_sum};

endmodule
`default_nettype wire

// File: doc/dadd_mch.md
# dadd_mch

Multi-channel, parametrised successor of the single-channel dadd datapath. Accepts address/data beats tagged with a channel number. Each beat is either added to a per-channel addend (ADD mode) or folded into a per-channel running sum (ACC mode). Results come out through a fixed-latency pipeline with ready/valid backpressure, and the address and channel travel alongside unchanged. It sits between the local bus driver and the result sink.

## Interface
Parameters:
- DW, 32, data width
- AW, 32, address width
- NCH, 4, channel count (≥1); CW = max(1, $clog2(NCH))
- LAT, 2, pipeline latency in cycles (≥1)
- SAT, 0, 1 = saturate on overflow, 0 = wrap

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- cfg_we  in  1  config write strobe
- cfg_ch  in  CW  channel being configured
- cfg_mode  in  1  0 = ADD, 1 = ACC
- cfg_addend  in  DW  addend for ADD mode
- dadd_in_en  in  1  input beat valid
- dadd_in_rdy  out  1  input beat accepted when en & rdy
- dadd_in_ch  in  CW  beat channel
- dadd_in_addr  in  AW  beat address
- dadd_in  in  DW  beat data
- dadd_out_en  out  1  result valid
- dadd_out_rdy  in  1  sink ready
- dadd_out_ch  out  CW  result channel
- dadd_out_addr  out  AW  result address (passthrough)
- dadd_out  out  DW  result data
- dadd_out_ovf  out  1  overflow occurred on this result

## Operation
- Accept = dadd_in_en & dadd_in_rdy. Beats with dadd_in_ch ≥ NCH are accepted and forwarded with result 0 and ovf 0; they do not touch any state.
- ADD mode: sum = dadd_in + addend[ch]. Accumulator is untouched.
- ACC mode: sum = acc[ch] + dadd_in. acc[ch] ← result. Output carries the new acc value.
- Overflow is the carry out of DW bits.
  - SAT=1: result = all-ones and ovf = 1. In ACC mode, acc stores the saturated value.
  - SAT=0: result = sum mod 2^DW and ovf = 1.
- Config write (cfg_we) loads addend[cfg_ch] and mode[cfg_ch] and clears acc[cfg_ch] to 0. A cfg_ch ≥ NCH is ignored.
- Same-cycle config write and accept on the same channel: the beat uses the old mode, addend and acc. The config write then wins, so acc ends at 0.
- Back-to-back ACC beats on one channel chain correctly at full rate, because acc is updated at accept time.
- Result order equals accept order. There is no reordering.

## Timing
- Reset values:
  - dadd_out_en, dadd_out, dadd_out_addr, dadd_out_ch, dadd_out_ovf all 0.
  - All addends 0, all modes ADD, all accumulators 0.
  - dadd_in_rdy = 0 while reset is high and 1 in the first cycle after.
- Reset mid-operation drops all in-flight beats; dadd_out_en is 0 in the next cycle.
- Latency: a beat accepted at edge k presents dadd_out_en = 1 in the cycle following edge k+LAT−1, i.e. LAT cycles after its accept cycle. Throughput is one beat per cycle.
- stall = dadd_out_en & ~dadd_out_rdy.
  - Stall freezes every pipeline stage, and outputs hold stable.
  - dadd_in_rdy = ~stall, a combinational path from dadd_out_rdy. This path is accepted.
- Bubbles travel like beats. A stage holding no valid beat does not block, so stall depends only on the output stage.
- Accumulator and config updates happen only on accept edges and cfg_we edges, never while a beat is stalled.

## Structure
- Package dadd_pkg:
  - dadd_mode_e {DADD_ADD = 0, DADD_ACC = 1}.
  - Pipeline stage struct {vld, ch, addr, data, ovf}.
  - Function sat_add(a, b, sat), returning {ovf, result}.
- Sub-module dadd_chan_regs: per-channel addend, mode and accumulator register file. It has a config write port, a read port for the accepting channel, and an acc write-back port. It handles the config-over-writeback priority.
- Top level holds the LAT-deep stage shift register with a common stall enable.

## Test plan
- Reset then 8 ADD beats: ch0 addend 5, dadd_in = 0..7, addr 0x100+i, out_rdy held 1 → outputs 5..12, addresses match, first dadd_out_en exactly LAT cycles after the first accept, no gaps.
- ACC on ch1: config mode ACC, then beats 10, 20, 30 back-to-back → outputs 10, 30, 60. A config write to ch1 followed by beat 7 → output 7.
- Overflow with DW=32, ADD addend 0xFFFF_FFF0, in 0x20:
  - SAT=0 → out 0x10, ovf 1.
  - SAT=1 → out 0xFFFF_FFFF, ovf 1; a following ACC beat of 1 stays at 0xFFFF_FFFF.
- Backpressure: out_rdy low for 3 cycles mid-stream → dadd_in_rdy low in those cycles, outputs held stable, no beat lost or duplicated. Scoreboard order matches over 1000 random beats with random out_rdy.
- Config collision: ch2 in ACC with acc = 50; same-cycle cfg_we(ch2, ACC) and beat 4 → output 54, and the next beat of 1 → output 1.
- Reset asserted with LAT beats in flight → no dadd_out_en after reset. A subsequent ch0 beat 3 → output 3 (addend and acc cleared).
